// File: rtl/store_buffer_unit_if.sv
// rtl/store_buffer_unit_if.sv - data-memory write port between the store buffer and memory
interface store_buffer_unit_if #(
  parameter int XLEN = 32
) ();
  localparam int LANES = XLEN / 8;

  logic             mem_req_valid;
  logic             mem_req_ready;
  logic             mem_rw_mode;
  logic [XLEN-1:0]  mem_addr;
  logic [XLEN-1:0]  mem_write_data;
  logic [LANES-1:0] mem_byte_en;

  modport master (
    output mem_req_valid,
    output mem_rw_mode,
    output mem_addr,
    output mem_write_data,
    output mem_byte_en,
    input  mem_req_ready
  );

  modport slave (
    input  mem_req_valid,
    input  mem_rw_mode,
    input  mem_addr,
    input  mem_write_data,
    input  mem_byte_en,
    output mem_req_ready
  );
endinterface

// File: rtl/store_buffer_unit.sv
// rtl/store_buffer_unit.sv - posted-write store FIFO with lane alignment and valid/ready drain
// Optional STORE_MISALIGN_SPLIT_EN: accept misaligned stores, splitting bus-word crossers into two beats.
module store_buffer_unit #(
  parameter int XLEN  = 32,
  parameter int DEPTH = 4
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_st_valid,
  input  logic [XLEN-1:0]        rs1_val,
  input  logic [XLEN-1:0]        rs2_val,
  input  logic [XLEN-1:0]        imm,
  input  logic [2:0]             store_control,
  output logic                   o_st_ready,
  output logic                   stall_pc,
  output logic                   ignore_curr_inst,
  output logic                   o_misalign_exc,
  output logic [$clog2(DEPTH):0] o_count,
  store_buffer_unit_if.master    mem
);
  localparam int LANES = XLEN / 8;
  localparam int OFFW  = $clog2(LANES);
  localparam int MW    = 2 * LANES;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = PW + 1;
`ifdef STORE_MISALIGN_SPLIT_EN
  localparam bit SPLIT_EN = 1'b1;
`else
  localparam bit SPLIT_EN = 1'b0;
`endif

  typedef enum logic [1:0] {IDLE, BEAT0, BEAT1} state_t;

  typedef struct packed {
    logic [XLEN-1:0]  addr;
    logic [XLEN-1:0]  data;
    logic [LANES-1:0] be;
    logic             split;
  } beat_t;

  // Lanes are built over a double-width window; the upper half is the second beat of a crossing store.
  function automatic beat_t beat_calc(input logic [XLEN-1:0] ea, input logic [XLEN-1:0] data,
                                      input logic [1:0] szl, input logic second);
    logic [OFFW-1:0]   off;
    logic [MW-1:0]     mask;
    logic [2*XLEN-1:0] wide;
    logic [XLEN-1:0]   base;
    beat_t             b;
    off  = ea[OFFW-1:0];
    mask = (MW'(1) << (4'd1 << szl)) - MW'(1);
    mask = mask << off;
    wide = {{XLEN{1'b0}}, data} << {off, 3'b000};
    base = {ea[XLEN-1:OFFW], {OFFW{1'b0}}};
    b.split = SPLIT_EN && (mask[MW-1:LANES] != '0);
    if (second) begin
      b.addr = base + XLEN'(LANES);
      b.data = wide[2*XLEN-1:XLEN];
      b.be   = mask[MW-1:LANES];
    end else begin
      b.addr = base;
      b.data = wide[XLEN-1:0];
      b.be   = mask[LANES-1:0];
    end
    return b;
  endfunction

  logic [XLEN-1:0]  fifo_ea_q   [DEPTH];
  logic [XLEN-1:0]  fifo_data_q [DEPTH];
  logic [1:0]       fifo_szl_q  [DEPTH];

  state_t           state_q, state_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mem_req_valid_q, mem_req_valid_d;
  logic             mem_rw_mode_q, mem_rw_mode_d;
  logic [XLEN-1:0]  mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]  mem_write_data_q, mem_write_data_d;
  logic [LANES-1:0] mem_byte_en_q, mem_byte_en_d;

  logic [XLEN-1:0]  ea;
  logic [1:0]       szl;
  logic             legal_op, misaligned, accept_ok, full, enq, accept, pop;
  logic [CW-1:0]    remain;
  beat_t            head0, head1, next0;

  always_comb begin
    ea         = rs1_val + imm;
    szl        = store_control[1:0];
    legal_op   = !store_control[2] && ((XLEN == 64) || (szl != 2'b11));
    misaligned = (ea[2:0] & ((3'd1 << szl) - 3'd1)) != 3'd0;
    accept_ok  = legal_op && (SPLIT_EN || !misaligned);
    full       = count_q == CW'(DEPTH);
    enq        = i_st_valid && !full && accept_ok;
    head0      = beat_calc(fifo_ea_q[rd_ptr_q], fifo_data_q[rd_ptr_q], fifo_szl_q[rd_ptr_q], 1'b0);
    head1      = beat_calc(fifo_ea_q[rd_ptr_q], fifo_data_q[rd_ptr_q], fifo_szl_q[rd_ptr_q], 1'b1);
    accept     = mem_req_valid_q && mem.mem_req_ready;
    pop        = accept && ((state_q == BEAT1) || !head0.split);
  end

  assign o_st_ready       = !full;
  assign stall_pc         = i_st_valid && full;
  assign ignore_curr_inst = i_st_valid && !accept_ok;
  assign o_misalign_exc   = i_st_valid && legal_op && misaligned && !SPLIT_EN;
  assign o_count          = count_q;

  assign mem.mem_req_valid  = mem_req_valid_q;
  assign mem.mem_rw_mode    = mem_rw_mode_q;
  assign mem.mem_addr       = mem_addr_q;
  assign mem.mem_write_data = mem_write_data_q;
  assign mem.mem_byte_en    = mem_byte_en_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q          <= IDLE;
      rd_ptr_q         <= '0;
      wr_ptr_q         <= '0;
      count_q          <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_rw_mode_q    <= 1'b0;
      mem_addr_q       <= '0;
      mem_write_data_q <= '0;
      mem_byte_en_q    <= '0;
    end else begin
      state_q          <= state_d;
      rd_ptr_q         <= rd_ptr_d;
      wr_ptr_q         <= wr_ptr_d;
      count_q          <= count_d;
      mem_req_valid_q  <= mem_req_valid_d;
      mem_rw_mode_q    <= mem_rw_mode_d;
      mem_addr_q       <= mem_addr_d;
      mem_write_data_q <= mem_write_data_d;
      mem_byte_en_q    <= mem_byte_en_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (enq) begin
      fifo_ea_q[wr_ptr_q]   <= ea;
      fifo_data_q[wr_ptr_q] <= rs2_val;
      fifo_szl_q[wr_ptr_q]  <= szl;
    end
  end

  always_comb begin
    count_d  = count_q + CW'(enq) - CW'(pop);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    wr_ptr_d = wr_ptr_q + PW'(enq);
    remain   = count_q - CW'(pop);
    state_d  = state_q;
    if ((state_q == IDLE) || accept) begin
      if ((state_q == BEAT0) && head0.split)
        state_d = BEAT1;
      else if (count_d != '0)
        state_d = BEAT0;
      else
        state_d = IDLE;
    end
  end

  // The next head is either an already-buffered entry or, when the FIFO drains empty, the incoming store.
  always_comb begin
    if (remain != '0)
      next0 = beat_calc(fifo_ea_q[rd_ptr_d], fifo_data_q[rd_ptr_d], fifo_szl_q[rd_ptr_d], 1'b0);
    else
      next0 = beat_calc(ea, rs2_val, szl, 1'b0);
    mem_req_valid_d  = state_d != IDLE;
    mem_rw_mode_d    = state_d != IDLE;
    mem_addr_d       = mem_addr_q;
    mem_write_data_d = mem_write_data_q;
    mem_byte_en_d    = mem_byte_en_q;
    if (state_d == IDLE) begin
      mem_addr_d       = '0;
      mem_write_data_d = '0;
      mem_byte_en_d    = '0;
    end else if ((state_q == IDLE) || accept) begin
      if (state_d == BEAT1) begin
        mem_addr_d       = head1.addr;
        mem_write_data_d = head1.data;
        mem_byte_en_d    = head1.be;
      end else begin
        mem_addr_d       = next0.addr;
        mem_write_data_d = next0.data;
        mem_byte_en_d    = next0.be;
      end
    end
  end
endmodule
